cpu_accel_fifo: RTL
===================

CPU_ACCEL_FIFO -- requirements
Module: cpu_accel_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the width of the data words on every port.
REQ-002 Parameter DEPTH, default 16, sets the entries per FIFO; it SHALL be a power of two and at least 2.
REQ-003 Parameter ACCEL_ID_WIDTH, default 4, sets the width of accel_id.
REQ-004 Parameter ACCEL_ID, default 1, is the accelerator id this block answers to.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with the ports below.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- accel_id  in  ACCEL_ID_WIDTH  accelerator selected by the CPU.
- accel_can_read  out  1  a word is available to the CPU.
- accel_can_write  out  1  the CPU may push a word.
- accel_read_enable  in  1  the CPU pops a word this cycle.
- accel_read_data  out  DATA_WIDTH  head word of the RX FIFO.
- accel_write_enable  in  1  the CPU pushes a word this cycle.
- accel_write_data  in  DATA_WIDTH  word the CPU pushes.
- out_valid  out  1  TX FIFO head is valid toward the consumer.
- out_ready  in  1  the consumer accepts the head word.
- out_data  out  DATA_WIDTH  TX FIFO head word.
- in_valid  in  1  the producer offers a word.
- in_ready  out  1  the RX FIFO can accept a word.
- in_data  in  DATA_WIDTH  word offered by the producer.
- overflow  out  1  sticky error flag.

Function
REQ-006 The block SHALL contain two independent FIFOs of DEPTH entries: TX (CPU to consumer) and RX (producer to CPU).
REQ-007 sel SHALL be defined as (accel_id == ACCEL_ID), a combinational signal.
REQ-008 accel_can_write SHALL equal sel AND NOT tx_full, and accel_can_read SHALL equal sel AND NOT rx_empty; both are combinational.
REQ-009 accel_read_data SHALL be combinational: the RX head word when sel AND NOT rx_empty, otherwise 0.
REQ-010 A TX push SHALL occur when accel_write_enable AND sel AND NOT tx_full.
REQ-011 A write with sel AND tx_full SHALL drop the word and set overflow.
REQ-012 A write with sel low SHALL be ignored with no effect on overflow.
REQ-013 An RX pop SHALL occur when accel_read_enable AND sel AND NOT rx_empty; a read enable while empty or while not selected SHALL have no effect.
REQ-014 out_valid SHALL equal NOT tx_empty and out_data SHALL be the TX head word, 0 when empty; a TX pop SHALL occur when out_valid AND out_ready.
REQ-015 in_ready SHALL equal NOT rx_full; an RX push SHALL occur when in_valid AND in_ready.
REQ-016 in_ready SHALL stay low when full even if a pop occurs in the same cycle (no full-bypass).
REQ-017 Each FIFO SHALL support a simultaneous push and pop in one cycle, with the count unchanged and both pointers advancing.
REQ-018 Each FIFO SHALL track its fill with read and write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.
REQ-019 The pointers SHALL wrap modulo DEPTH.
REQ-020 full SHALL be count==DEPTH and empty SHALL be count==0.
REQ-021 A pushed word SHALL be visible at the head on the cycle after the push edge: one cycle of latency, no fall-through.
REQ-022 Word order SHALL be strictly preserved through each FIFO.
REQ-023 overflow SHALL be sticky and cleared only by rst.

Reset
REQ-024 While rst is high at a clk edge, both FIFO counts and all pointers SHALL go to 0 and overflow SHALL go to 0.
REQ-025 Consequently, in the cycle after a reset edge, out_valid=0, out_data=0, accel_can_read=0, accel_read_data=0, in_ready=1, and accel_can_write=sel.
REQ-026 Reset SHALL take priority over any same-cycle push or pop, and in-flight contents SHALL be discarded.
REQ-027 Storage RAM contents need not be cleared by reset.

Verification
REQ-028 Defaults, CPU write: accel_id=1, writes 10, 20, 30 with out_ready=0 -> out_valid=1, out_data=10; then out_ready=1 -> out_data sequence 10, 20, 30 on successive cycles, then out_valid=0.
REQ-029 TX full: write 17 words 0..16 with out_ready=0 -> accel_can_write=0 after the 16th word, word 16 dropped, overflow=1; drain -> 0..15 in order.
REQ-030 RX: producer pushes 5, 6 with accel_id=2 -> accel_can_read=0, accel_read_data=0; switch to accel_id=1 -> accel_read_data=5; read_enable -> next cycle accel_read_data=6.
REQ-031 RX full plus same-cycle pop: fill RX with 16 words -> in_ready=0; assert read_enable and in_valid together -> no push that cycle, count=15, in_ready=1 next cycle.
REQ-032 Wrap: stream 40 words through each FIFO with simultaneous push and pop at count=8 -> data intact and in order across pointer wrap.
REQ-033 Mid-operation reset: 8 words in TX, assert rst for 1 cycle during a push -> out_valid=0, overflow=0, and the next write appears at out_data one cycle later.

Source files
------------

// File: rtl/cpu_accel_fifo.sv
// CPU-side accelerator port: a TX FIFO (CPU -> consumer) and an RX FIFO
// (producer -> CPU), both gated by an accelerator-id select, plus a sticky overflow flag.

module cpu_accel_fifo_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wdata;
  end
endmodule

module cpu_accel_fifo #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int ACCEL_ID_WIDTH = 4,
  parameter int ACCEL_ID       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ACCEL_ID_WIDTH-1:0] accel_id,
  output logic                      accel_can_read,
  output logic                      accel_can_write,
  input  logic                      accel_read_enable,
  output logic [DATA_WIDTH-1:0]     accel_read_data,
  input  logic                      accel_write_enable,
  input  logic [DATA_WIDTH-1:0]     accel_write_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      overflow
);
  logic                  sel;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic [DATA_WIDTH-1:0] tx_head, rx_head;

  assign sel     = (accel_id == ACCEL_ID_WIDTH'(ACCEL_ID));
  assign tx_push = accel_write_enable & sel & ~tx_full;
  assign tx_pop  = ~tx_empty & out_ready;
  // No full-bypass: a same-cycle pop does not open the RX input.
  assign rx_push = in_valid & ~rx_full;
  assign rx_pop  = accel_read_enable & sel & ~rx_empty;

  cpu_accel_fifo_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(accel_write_data),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  cpu_accel_fifo_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(in_data),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign accel_can_write = sel & ~tx_full;
  assign accel_can_read  = sel & ~rx_empty;
  assign accel_read_data = (sel & ~rx_empty) ? rx_head : '0;
  assign out_valid       = ~tx_empty;
  assign out_data        = tx_empty ? '0 : tx_head;
  assign in_ready        = ~rx_full;

  always_ff @(posedge clk) begin
    if (rst)                                  overflow <= 1'b0;
    else if (accel_write_enable & sel & tx_full) overflow <= 1'b1;
  end
endmodule
